// File: rtl/mod_n_pkg.sv
// Shared types and arithmetic for the serial mod-N checker: FSM state enum,
// remainder width helper and the single-bit remainder step.
package mod_n_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Remainder width: enough bits for 0..d-1, never less than one.
  function automatic int unsigned rem_w(input int unsigned d);
    return (d > 2) ? $clog2(d) : 1;
  endfunction

  // rem' = 2*rem + b, reduced once; 2*rem + b < 2*d keeps one subtract exact.
  function automatic int unsigned rem_step(input int unsigned rem, input logic b,
                                           input int unsigned d);
    int unsigned s;
    s = (rem << 1) + {31'd0, b};
    return (s >= d) ? (s - d) : s;
  endfunction

endpackage

// File: rtl/mod_n_serial_checker_if.sv
// Handshake bundle of the serial mod-N checker: bit input stream, result output
// stream and the synchronous abort.
interface mod_n_serial_checker_if
  import mod_n_pkg::*;
#(
  parameter int unsigned DIVISOR = 3
) ();
  localparam int unsigned REM_W = rem_w(DIVISOR);

  logic             clear;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             out_div;
  logic [REM_W-1:0] out_rem;

  modport master (
    output clear, in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_div, out_rem
  );

  modport slave (
    input  clear, in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_div, out_rem
  );
endinterface

// File: rtl/mod_n_step.sv
// One bit of the running remainder: rem_o = (2*rem_i + bit_i) mod DIVISOR.
module mod_n_step
  import mod_n_pkg::*;
#(
  parameter int unsigned DIVISOR = 3
) (
  input  logic [rem_w(DIVISOR)-1:0] rem_i,
  input  logic                      bit_i,
  output logic [rem_w(DIVISOR)-1:0] rem_o
);
  localparam int unsigned REM_W = rem_w(DIVISOR);

  assign rem_o = REM_W'(rem_step(32'(rem_i), bit_i, DIVISOR));
endmodule

// File: rtl/mod_n_serial_checker.sv
// Serial divisibility checker: folds MSB-first frames of FRAME_BITS bits into a
// remainder mod DIVISOR and holds one result until the consumer takes it.
module mod_n_serial_checker
  import mod_n_pkg::*;
#(
  parameter int unsigned DIVISOR    = 3,
  parameter int unsigned FRAME_BITS = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  mod_n_serial_checker_if.slave io
);
  localparam int unsigned     REM_W = rem_w(DIVISOR);
  localparam int unsigned     CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BITS - 1);

  state_e           state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d, rem_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REM_W-1:0] out_rem_q, out_rem_d;
  logic             out_div_q, out_div_d;
  logic             in_ready, accept;

  mod_n_step #(.DIVISOR(DIVISOR)) u_step (
    .rem_i (rem_q),
    .bit_i (io.in_bit),
    .rem_o (rem_nxt)
  );

  // In HOLD a new bit may only enter when the pending result leaves this cycle.
  assign in_ready = (state_q == ACCUM) || io.out_ready;
  assign accept   = io.in_valid && in_ready;

  assign io.in_ready  = in_ready;
  assign io.out_valid = (state_q == HOLD);
  assign io.out_div   = out_div_q;
  assign io.out_rem   = out_rem_q;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    out_rem_d = out_rem_q;
    out_div_d = out_div_q;
    if (io.clear) begin
      state_d = ACCUM;
      rem_d   = '0;
      cnt_d   = '0;
    end else if (accept) begin
      if (cnt_q == LAST) begin
        out_rem_d = rem_nxt;
        out_div_d = (rem_nxt == '0);
        rem_d     = '0;
        cnt_d     = '0;
        state_d   = HOLD;
      end else begin
        rem_d   = rem_nxt;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ACCUM;
      end
    end else if ((state_q == HOLD) && io.out_ready) begin
      state_d = ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      rem_q     <= '0;
      cnt_q     <= '0;
      out_rem_q <= '0;
      out_div_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      out_rem_q <= out_rem_d;
      out_div_q <= out_div_d;
    end
  end
endmodule

// File: tb/tb_mod_n_serial_checker.sv
// Scoreboard bench for mod_n_serial_checker: frame values queued on send,
// checked against value % DIVISOR when the result handshake fires.
module tb_mod_n_serial_checker;
  import mod_n_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mod_n_serial_checker_if #(.DIVISOR(3)) if3 ();
  mod_n_serial_checker_if #(.DIVISOR(7)) if7 ();

  mod_n_serial_checker #(.DIVISOR(3), .FRAME_BITS(4)) u_dut3 (
    .clk (clk), .rst_n (rst_n), .io (if3.slave)
  );
  mod_n_serial_checker #(.DIVISOR(7), .FRAME_BITS(8)) u_dut7 (
    .clk (clk), .rst_n (rst_n), .io (if7.slave)
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int unsigned q3[$];
  int unsigned q7[$];
  int          tq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && if3.out_valid && if3.out_ready) begin
      if (q3.size() == 0) chk("spurious3", 32'(if3.out_valid), 0);
      else begin
        int unsigned e;
        e = q3.pop_front();
        chk("rem3", 32'(if3.out_rem), e % 3);
        chk("div3", 32'(if3.out_div), 32'(e % 3 == 0));
        tq.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if7.out_valid && if7.out_ready) begin
      if (q7.size() == 0) chk("spurious7", 32'(if7.out_valid), 0);
      else begin
        int unsigned e;
        e = q7.pop_front();
        chk("rem7", 32'(if7.out_rem), e % 7);
        chk("div7", 32'(if7.out_div), 32'(e % 7 == 0));
      end
    end
  end

  // Drives nb bits of v MSB first; leaves in_valid high for streaming.
  task automatic send3(input logic [63:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) begin
      int w;
      if3.in_valid = 1'b1;
      if3.in_bit   = v[i];
      w = 0;
      @(negedge clk);
      while (!if3.in_ready && w < 50) begin @(negedge clk); w++; end
      chk("rdy3", 32'(if3.in_ready), 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic send7(input logic [63:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) begin
      int w;
      if7.in_valid = 1'b1;
      if7.in_bit   = v[i];
      w = 0;
      @(negedge clk);
      while (!if7.in_ready && w < 50) begin @(negedge clk); w++; end
      chk("rdy7", 32'(if7.in_ready), 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((q3.size() != 0 || q7.size() != 0) && w < 200) begin @(negedge clk); w++; end
    chk("drain3", q3.size(), 0);
    chk("drain7", q7.size(), 0);
    @(negedge clk);
    chk("idle_vld3", 32'(if3.out_valid), 0);
    chk("idle_vld7", 32'(if7.out_valid), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    if3.clear = 0; if3.in_valid = 0; if3.in_bit = 0; if3.out_ready = 0;
    if7.clear = 0; if7.in_valid = 0; if7.in_bit = 0; if7.out_ready = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_vld3", 32'(if3.out_valid), 0);
    chk("rst_rem3", 32'(if3.out_rem), 0);
    chk("rst_div3", 32'(if3.out_div), 0);
    chk("rst_vld7", 32'(if7.out_valid), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rdy_after_rst", 32'(if3.in_ready), 1);
    @(posedge clk); #1;

    // basic frames
    if3.out_ready = 1; if7.out_ready = 1;
    send3(9, 4);  q3.push_back(9);
    send3(10, 4); q3.push_back(10);
    send3(0, 4);  q3.push_back(0);
    if3.in_valid = 0;
    drain();

    // back-pressure, then consume-and-accept in one cycle, then streaming
    if3.out_ready = 0;
    send3(15, 4); q3.push_back(15);
    if3.in_valid = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rdy", 32'(if3.in_ready), 0);
      chk("bp_vld", 32'(if3.out_valid), 1);
      chk("bp_rem", 32'(if3.out_rem), 0);
    end
    @(posedge clk); #1;
    tq.delete();
    if3.out_ready = 1; if3.in_valid = 1; if3.in_bit = 1;
    @(negedge clk);
    chk("cons_rdy", 32'(if3.in_ready), 1);
    chk("cons_vld", 32'(if3.out_valid), 1);
    @(posedge clk); #1;
    send3(3, 3);  q3.push_back(11);
    send3(5, 4);  q3.push_back(5);
    send3(12, 4); q3.push_back(12);
    if3.in_valid = 0;
    drain();
    chk("stream_n", tq.size(), 4);
    for (int k = 1; k < tq.size(); k++) chk("stream_gap", tq[k] - tq[k-1], 4);

    // wider modulus
    send7(8'hFF, 8); q7.push_back(255);
    send7(8'hFC, 8); q7.push_back(252);
    send7(8'h64, 8); q7.push_back(100);
    if7.in_valid = 0;
    drain();

    // clear mid-frame discards the partial bits and the same-cycle bit
    send3(3, 2);
    if3.clear = 1; if3.in_valid = 1; if3.in_bit = 1;
    @(posedge clk); #1;
    if3.clear = 0;
    send3(6, 4); q3.push_back(6);
    if3.in_valid = 0;
    drain();

    // async reset while holding a result
    if3.out_ready = 0;
    send3(5, 4);
    if3.in_valid = 0;
    @(negedge clk);
    chk("hold_vld", 32'(if3.out_valid), 1);
    chk("hold_rem", 32'(if3.out_rem), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(if3.out_valid), 0);
    chk("arst_rem", 32'(if3.out_rem), 0);
    chk("arst_rdy", 32'(if3.in_ready), 1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    if3.out_ready = 1;

    // async reset mid-frame: next frame counts from bit 1
    send3(3, 2);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    send3(9, 4); q3.push_back(9);
    if3.in_valid = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mod_n_serial_checker.md
MOD_N_SERIAL_CHECKER -- requirements
Module: mod_n_serial_checker

Interface
REQ-001 The block SHALL have parameter DIVISOR, default 3, the modulus tested; legal range 2..255.
REQ-002 The block SHALL have parameter FRAME_BITS, default 4, the number of bits per frame; legal range 1..64.
REQ-003 The block SHALL derive localparam REM_W = max(1, $clog2(DIVISOR)), the remainder width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 clear  input  1  synchronous frame abort.
REQ-007 in_valid  input  1  in_bit is offered.
REQ-008 in_bit  input  1  serial data bit, MSB of the frame first.
REQ-009 in_ready  output  1  block accepts in_bit this cycle.
REQ-010 out_valid  output  1  frame result is held on out_div/out_rem.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 out_div  output  1  1 when frame value mod DIVISOR == 0.
REQ-013 out_rem  output  REM_W  frame value mod DIVISOR.

Function
REQ-014 A bit SHALL be accepted only on a cycle where in_valid && in_ready.
REQ-015 The FSM SHALL have exactly two states: ACCUM (collecting bits) and HOLD (result pending).
REQ-016 On each accepted bit, the running remainder SHALL update to rem' = 2*rem + in_bit, minus DIVISOR if the result is >= DIVISOR. One conditional subtract is sufficient because 2*rem + in_bit < 2*DIVISOR.
REQ-017 The bit counter SHALL count accepted bits 0..FRAME_BITS-1.
REQ-018 The counter width SHALL be $clog2(FRAME_BITS+1).
REQ-019 When the FRAME_BITS-th bit is accepted in ACCUM, the FSM SHALL, on the same edge:
- register out_rem = rem' and out_div = (rem' == 0);
- zero rem and count;
- enter HOLD.
REQ-020 Result latency SHALL be one cycle: out_valid is high in the cycle after the last bit is accepted.
REQ-021 in_ready SHALL be 1 in ACCUM, and (out_ready) in HOLD. No extra buffering beyond the single result register.
REQ-022 In HOLD with out_ready high, the result SHALL be consumed. The FSM SHALL go to ACCUM unless a bit accepted that cycle completes a new frame.
REQ-023 A bit accepted in HOLD while the result is consumed SHALL count as bit 1 of the next frame, so streaming has no bubble.
REQ-024 If FRAME_BITS == 1, a bit accepted in HOLD while the result is consumed SHALL complete a frame. The FSM stays in HOLD with the new result.
REQ-025 out_valid, out_div and out_rem SHALL stay stable while out_valid && !out_ready.
REQ-026 clear SHALL have priority over every other event. It zeros rem and count, drops out_valid, enters ACCUM, and discards any same-cycle bit.
REQ-027 in_ready SHALL be combinationally independent of in_valid.

Reset
REQ-028 While rst_n is low, state SHALL be ACCUM, and rem, count, out_valid, out_div and out_rem SHALL all be 0, immediately and regardless of clk.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame. The first accepted bit after rst_n deasserts is bit 1 of a new frame.
REQ-030 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-031 Package mod_n_pkg SHALL hold the state enum type (ACCUM, HOLD) and the remainder-step function shared by the RTL and the bench model.
REQ-032 The remainder update SHALL be a sub-module, mod_n_step: inputs rem and bit, output rem', parameter DIVISOR, purely combinational.
REQ-033 All other logic SHALL reside in mod_n_serial_checker.

Verification
REQ-034 Basic frames, DIVISOR=3, FRAME_BITS=4, out_ready=1:
- bits 1,0,0,1 (value 9) -> out_valid for 1 cycle, out_div=1, out_rem=0;
- bits 1,0,1,0 (value 10) -> out_div=0, out_rem=1;
- bits 0,0,0,0 -> out_div=1, out_rem=0.
REQ-035 Back-pressure and streaming, DIVISOR=3, FRAME_BITS=4:
- out_ready=0 after frame 1,1,1,1 (value 15) -> in_ready=0 and out_rem=0 held for 5 cycles;
- then out_ready=1 with in_valid=1 -> the result is consumed and the bit is accepted in the same cycle;
- continuous in_valid with out_ready=1 -> one result every 4 cycles, no gaps.
REQ-036 Wider modulus, DIVISOR=7, FRAME_BITS=8:
- 0xFF -> out_rem=3, out_div=0;
- 0xFC -> out_rem=0, out_div=1.
REQ-037 Clear: clear pulsed after 2 bits of a frame, then 4 bits 0,1,1,0 (value 6), DIVISOR=3 -> a single result with out_div=1, out_rem=0; nothing is emitted for the aborted bits.
REQ-038 Asynchronous reset: rst_n pulsed low between clock edges while in HOLD -> out_valid=0 immediately; the next full frame is counted from bit 1.
